// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
`timescale 1ns/1ps
package hazard_pkg;

   localparam int NCTRL_DEF  = 12;
   localparam int REG_AW_DEF = 5;
   localparam int STAT_W_DEF = 16;

   // Width of the flush down-counter; FLUSH_CYCLES is limited to 1..15.
   localparam int FCNT_W = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-control bundle between the hazard controller and the datapath.
`timescale 1ns/1ps
interface hazard_if
   import hazard_pkg::*;
#(
   parameter int NCTRL  = NCTRL_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int STAT_W = STAT_W_DEF
);
   logic [NCTRL-1:0]  ctrl_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic              id_uses_rs1_i;
   logic              id_uses_rs2_i;
   logic [REG_AW-1:0] ex_rd_i;
   logic              ex_mem_read_i;
   logic              redirect_i;
   logic              mem_busy_i;
   logic              clear_stats_i;
   logic [NCTRL-1:0]  ctrl_o;
   logic              pc_write_o;
   logic              if_id_write_o;
   logic              if_id_flush_o;
   logic              pipe_hold_o;
   logic [STAT_W-1:0] stall_count_o;
   logic [STAT_W-1:0] flush_count_o;

   modport master (
      output ctrl_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
             ex_rd_i, ex_mem_read_i, redirect_i, mem_busy_i, clear_stats_i,
      input  ctrl_o, pc_write_o, if_id_write_o, if_id_flush_o, pipe_hold_o,
             stall_count_o, flush_count_o
   );

   modport slave (
      input  ctrl_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
             ex_rd_i, ex_mem_read_i, redirect_i, mem_busy_i, clear_stats_i,
      output ctrl_o, pc_write_o, if_id_write_o, if_id_flush_o, pipe_hold_o,
             stall_count_o, flush_count_o
   );

endinterface

// File: rtl/ctrl_bubble_mux.sv
// Turns the ID control bundle into a bubble, keeping only the KEEP_MASK bits.
`timescale 1ns/1ps
module ctrl_bubble_mux #(
   parameter int               NCTRL     = 12,
   parameter logic [NCTRL-1:0] KEEP_MASK = '0
) (
   input  logic [NCTRL-1:0] ctrl,
   input  logic             bubble,
   output logic [NCTRL-1:0] gated
);

   assign gated = bubble ? (ctrl & KEEP_MASK) : ctrl;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for a 5-stage pipeline: load-use stalls, redirect
// flushes, memory-wait holds, plus saturating stall/flush statistics.
`timescale 1ns/1ps
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int               NCTRL        = NCTRL_DEF,
   parameter logic [NCTRL-1:0] KEEP_MASK    = '0,
   parameter int               REG_AW       = REG_AW_DEF,
   parameter int               FLUSH_CYCLES = 2,
   parameter int               STAT_W       = STAT_W_DEF
) (
   input  logic     clk,
   input  logic     reset,
   hazard_if.slave  bus
);

   localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

   hz_state_e         state_q, state_d, ret_q, ret_d, eff_state;
   logic [FCNT_W-1:0] cnt_q, cnt_d;
   logic [STAT_W-1:0] stall_q, flush_q;

   logic load_use, redirect_taken;
   logic pc_write, if_id_write, if_id_flush, pipe_hold, bubble;

   assign load_use = bus.ex_mem_read_i && (bus.ex_rd_i != REG_AW'(0)) &&
                     ((bus.id_uses_rs1_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                      (bus.id_uses_rs2_i && (bus.id_rs2_i == bus.ex_rd_i)));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         ret_q   <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      ret_d          = ret_q;
      cnt_d          = cnt_q;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_id_flush    = 1'b0;
      pipe_hold      = 1'b0;
      bubble         = 1'b0;
      redirect_taken = 1'b0;

      // Once memory is ready again, MEM_WAIT behaves as the state it interrupted.
      eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

      if (bus.mem_busy_i) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
         state_d     = MEM_WAIT;
         if (state_q != MEM_WAIT) ret_d = state_q;
      end else if (bus.redirect_i) begin
         if_id_flush    = 1'b1;
         bubble         = 1'b1;
         redirect_taken = 1'b1;
         cnt_d          = FLUSH_RELOAD;
         state_d        = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (eff_state == FLUSH) begin
         if_id_flush = 1'b1;
         bubble      = 1'b1;
         cnt_d       = cnt_q - FCNT_W'(1);
         state_d     = (cnt_q <= FCNT_W'(1)) ? RUN : FLUSH;
      end else begin
         state_d = RUN;
         if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
         end
      end

      // While in reset the pipeline is frozen and fed bubbles.
      if (!reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b0;
         pipe_hold   = 1'b0;
         bubble      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else if (bus.clear_stats_i) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write && (stall_q != '1))      stall_q <= stall_q + STAT_W'(1);
         if (redirect_taken && (flush_q != '1)) flush_q <= flush_q + STAT_W'(1);
      end
   end

   ctrl_bubble_mux #(
      .NCTRL     (NCTRL),
      .KEEP_MASK (KEEP_MASK)
   ) u_bubble (
      .ctrl   (bus.ctrl_i),
      .bubble (bubble),
      .gated  (bus.ctrl_o)
   );

   assign bus.pc_write_o    = pc_write;
   assign bus.if_id_write_o = if_id_write;
   assign bus.if_id_flush_o = if_id_flush;
   assign bus.pipe_hold_o   = pipe_hold;
   assign bus.stall_count_o = stall_q;
   assign bus.flush_count_o = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed and random checks of hazard_control_unit against a cycle-level model
// that tracks only "flush cycles still owed" and plain event counts.
`timescale 1ns/1ps
module tb_hazard_control_unit;

   localparam int               NC = hazard_pkg::NCTRL_DEF;
   localparam int               AW = hazard_pkg::REG_AW_DEF;
   localparam int               FC = 3;
   localparam logic [NC-1:0]    KM = 12'h0F3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NC-1:0] ctrl;
   logic [AW-1:0] rs1, rs2, rd;
   logic          u1, u2, mr, redir, busy, clr;

   hazard_if #(.NCTRL(NC), .REG_AW(AW), .STAT_W(16)) bus0 ();
   hazard_if #(.NCTRL(NC), .REG_AW(AW), .STAT_W(2))  bus1 ();

   assign bus0.ctrl_i = ctrl;          assign bus1.ctrl_i = ctrl;
   assign bus0.id_rs1_i = rs1;         assign bus1.id_rs1_i = rs1;
   assign bus0.id_rs2_i = rs2;         assign bus1.id_rs2_i = rs2;
   assign bus0.id_uses_rs1_i = u1;     assign bus1.id_uses_rs1_i = u1;
   assign bus0.id_uses_rs2_i = u2;     assign bus1.id_uses_rs2_i = u2;
   assign bus0.ex_rd_i = rd;           assign bus1.ex_rd_i = rd;
   assign bus0.ex_mem_read_i = mr;     assign bus1.ex_mem_read_i = mr;
   assign bus0.redirect_i = redir;     assign bus1.redirect_i = redir;
   assign bus0.mem_busy_i = busy;      assign bus1.mem_busy_i = busy;
   assign bus0.clear_stats_i = clr;    assign bus1.clear_stats_i = clr;

   hazard_control_unit #(
      .NCTRL(NC), .KEEP_MASK(KM), .REG_AW(AW), .FLUSH_CYCLES(FC), .STAT_W(16)
   ) dut (.clk(clk), .reset(reset), .bus(bus0));

   hazard_control_unit #(
      .NCTRL(NC), .KEEP_MASK(KM), .REG_AW(AW), .FLUSH_CYCLES(FC), .STAT_W(2)
   ) dut_narrow (.clk(clk), .reset(reset), .bus(bus1));

   int          n_tests = 0;
   int          n_fail  = 0;
   int          fl_left = 0;
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;
   int          flush_hi, hold_hi;

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      ctrl = NC'($urandom); rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0;
      u1 = 1'b0; u2 = 1'b0; mr = 1'b0; redir = 1'b0; busy = 1'b0; clr = 1'b0;
   endtask

   // One clock cycle: predict outputs from the rules, compare, then advance.
   task automatic tick();
      logic e_pc, e_ifid, e_fl, e_hold, e_bub, lu;
      logic [NC-1:0] e_ctrl;
      #1;
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e_pc = 1'b1; e_ifid = 1'b1; e_fl = 1'b0; e_hold = 1'b0; e_bub = 1'b0;
      if (!reset)          begin e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1; end
      else if (busy)       begin e_pc = 1'b0; e_ifid = 1'b0; e_hold = 1'b1; end
      else if (redir)      begin e_fl = 1'b1; e_bub = 1'b1; end
      else if (fl_left > 0) begin e_fl = 1'b1; e_bub = 1'b1; end
      else if (lu)         begin e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1; end
      e_ctrl = e_bub ? (ctrl & KM) : ctrl;

      check("pc_write", 32'(bus0.pc_write_o), 32'(e_pc));
      check("if_id_write", 32'(bus0.if_id_write_o), 32'(e_ifid));
      check("if_id_flush", 32'(bus0.if_id_flush_o), 32'(e_fl));
      check("pipe_hold", 32'(bus0.pipe_hold_o), 32'(e_hold));
      check("ctrl", 32'(bus0.ctrl_o), 32'(e_ctrl));
      check("stall_count", 32'(bus0.stall_count_o), 32'(sat(m_stall, 32'hFFFF)));
      check("flush_count", 32'(bus0.flush_count_o), 32'(sat(m_flush, 32'hFFFF)));
      check("stall_count_w2", 32'(bus1.stall_count_o), 32'(sat(m_stall, 3)));
      check("flush_count_w2", 32'(bus1.flush_count_o), 32'(sat(m_flush, 3)));
      if (bus0.if_id_flush_o) flush_hi++;
      if (bus0.pipe_hold_o)   hold_hi++;

      @(posedge clk);
      if (reset) begin
         if (clr) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (!e_pc) m_stall++;
            if (!busy && redir) m_flush++;
         end
         if (!busy) begin
            if (redir)            fl_left = FC - 1;
            else if (fl_left > 0) fl_left--;
         end
      end
      #1;
   endtask

   task automatic clear_stats();
      idle(); clr = 1'b1; tick(); clr = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #2;
      tick(); tick();
      reset = 1'b1;
      idle(); tick();

      // Load x5 in EX, rs2=x5 read in ID: one stall cycle.
      clear_stats();
      mr = 1'b1; rd = 5'd5; rs2 = 5'd5; u2 = 1'b1; ctrl = '1;
      tick();
      check("s1_stall_count", 32'(bus0.stall_count_o), 32'd1);
      // Load to x0 never stalls.
      mr = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1;
      tick();
      check("s1_x0_stall_count", 32'(bus0.stall_count_o), 32'd1);

      // Single redirect: flush lasts FC cycles.
      clear_stats();
      flush_hi = 0;
      redir = 1'b1; tick(); redir = 1'b0;
      repeat (4) tick();
      check("s2_flush_len", 32'(flush_hi), 32'd3);
      check("s2_flush_count", 32'(bus0.flush_count_o), 32'd1);

      // Redirect again in the second FLUSH-state cycle: 2 + 3 flush cycles.
      clear_stats();
      flush_hi = 0;
      redir = 1'b1; tick(); redir = 1'b0;
      tick();
      redir = 1'b1; tick(); redir = 1'b0;
      repeat (4) tick();
      check("s3_flush_len", 32'(flush_hi), 32'd5);
      check("s3_flush_count", 32'(bus0.flush_count_o), 32'd2);

      // Memory busy for 4 cycles starting in the second flush cycle.
      clear_stats();
      redir = 1'b1; tick(); redir = 1'b0;
      hold_hi = 0;
      busy = 1'b1; repeat (4) tick(); busy = 1'b0;
      check("s4_hold_len", 32'(hold_hi), 32'd4);
      flush_hi = 0;
      repeat (4) tick();
      check("s4_flush_after_wait", 32'(flush_hi), 32'd2);

      // Load-use together with redirect: the flush wins, nothing stalls.
      clear_stats();
      mr = 1'b1; rd = 5'd7; rs1 = 5'd7; u1 = 1'b1; redir = 1'b1;
      tick();
      check("s5_stall_count", 32'(bus0.stall_count_o), 32'd0);
      check("s5_flush_count", 32'(bus0.flush_count_o), 32'd1);
      idle(); repeat (3) tick();

      // Five stalls saturate the 2-bit counter at 3; clear brings it back to 0.
      clear_stats();
      mr = 1'b1; rd = 5'd3; rs1 = 5'd3; u1 = 1'b1;
      repeat (5) tick();
      idle(); tick();
      check("s6_sat_w2", 32'(bus1.stall_count_o), 32'd3);
      check("s6_count_w16", 32'(bus0.stall_count_o), 32'd5);
      clear_stats();
      tick();
      check("s6_cleared_w2", 32'(bus1.stall_count_o), 32'd0);

      // Reset asserted mid-MEM_WAIT.
      busy = 1'b1; tick(); tick();
      reset = 1'b0;
      #1;
      fl_left = 0; m_stall = 0; m_flush = 0;
      check("s6_rst_pc_write", 32'(bus0.pc_write_o), 32'd0);
      check("s6_rst_pipe_hold", 32'(bus0.pipe_hold_o), 32'd0);
      check("s6_rst_ctrl", 32'(bus0.ctrl_o), 32'(ctrl & KM));
      check("s6_rst_stall_count", 32'(bus0.stall_count_o), 32'd0);
      busy = 1'b0;
      tick();
      reset = 1'b1;
      idle(); tick();
      check("s6_run_after_rst", 32'(bus0.pc_write_o), 32'd1);

      // Random traffic, biased towards hazards.
      for (int i = 0; i < 400; i++) begin
         ctrl  = NC'($urandom);
         rd    = AW'($urandom_range(0, 3));
         rs1   = AW'($urandom_range(0, 3));
         rs2   = AW'($urandom_range(0, 3));
         u1    = 1'($urandom);
         u2    = 1'($urandom);
         mr    = 1'($urandom);
         redir = ($urandom_range(0, 7) == 0);
         busy  = ($urandom_range(0, 5) == 0);
         clr   = ($urandom_range(0, 40) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter NCTRL, default 12: width of the ID-stage control bundle.
REQ-002 Parameter KEEP_MASK, default 0 (NCTRL bits): bundle bits that pass unchanged during a bubble.
REQ-003 Parameter REG_AW, default 5: register address width.
REQ-004 Parameter FLUSH_CYCLES, default 2, range 1..15: cycles of IF/ID flush per redirect.
REQ-005 Parameter STAT_W, default 16: width of the statistics counters.
REQ-006 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-007 Port list (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ctrl_i  in  NCTRL  decoded control bundle
- id_rs1_i, id_rs2_i  in  REG_AW  source registers in ID
- id_uses_rs1_i, id_uses_rs2_i  in  1  source is actually read
- ex_rd_i  in  REG_AW  destination register in EX
- ex_mem_read_i  in  1  EX instruction is a load
- redirect_i  in  1  taken branch, JAL or JALR resolved in EX
- mem_busy_i  in  1  data memory not ready
- clear_stats_i  in  1  synchronous clear of the counters
- ctrl_o  out  NCTRL  bundle to ID/EX, bubbled when required
- pc_write_o  out  1  PC enable
- if_id_write_o  out  1  IF/ID enable
- if_id_flush_o  out  1  squash IF/ID
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB
- stall_count_o  out  STAT_W  cycles with pc_write_o=0
- flush_count_o  out  STAT_W  accepted redirects

Function
REQ-008 Bubble SHALL be defined as ctrl_o = ctrl_i AND KEEP_MASK; otherwise ctrl_o = ctrl_i.
REQ-009 The FSM SHALL have exactly three states: RUN, FLUSH and MEM_WAIT.
REQ-010 Load-use hazard SHALL be defined as ex_mem_read_i & (ex_rd_i != 0) & ((id_uses_rs1_i & id_rs1_i == ex_rd_i) | (id_uses_rs2_i & id_rs2_i == ex_rd_i)).
REQ-011 Per-cycle priority SHALL be: mem_busy_i, then redirect_i, then load-use.
REQ-012 RUN with a load-use hazard SHALL, combinationally and in the same cycle, drive pc_write_o=0 and if_id_write_o=0 and bubble ctrl_o; the state SHALL remain RUN.
REQ-013 RUN with redirect_i SHALL, in the same cycle, drive if_id_flush_o=1 and bubble ctrl_o, and SHALL increment flush_count_o.
- If FLUSH_CYCLES > 1: go to FLUSH with the counter loaded with FLUSH_CYCLES-1.
- Otherwise: stay in RUN.
REQ-014 FLUSH SHALL drive if_id_flush_o=1, bubble ctrl_o and decrement the counter each cycle; when the counter reaches 1, the next state SHALL be RUN.
REQ-015 Load-use detection SHALL be suppressed in FLUSH.
REQ-016 redirect_i in FLUSH SHALL reload the counter to FLUSH_CYCLES-1 and count as a new redirect.
REQ-017 mem_busy_i in any state SHALL, in the same cycle, drive pc_write_o=0, if_id_write_o=0 and pipe_hold_o=1, with ctrl_o = ctrl_i.
- The next state SHALL be MEM_WAIT.
- The return state (RUN or FLUSH) SHALL be saved.
REQ-018 MEM_WAIT SHALL hold the outputs of REQ-017 and freeze the flush counter.
- redirect_i and load-use SHALL be ignored.
- The cycle after mem_busy_i falls, the FSM SHALL re-enter the saved state.
REQ-019 In all other cases, outputs SHALL be pc_write_o=1, if_id_write_o=1, if_id_flush_o=0, pipe_hold_o=0 and ctrl_o = ctrl_i.
REQ-020 stall_count_o SHALL increment in every cycle with pc_write_o=0.
REQ-021 Both counters SHALL saturate at all-ones; clear_stats_i SHALL zero both and override an increment in the same cycle.

Reset
REQ-022 While reset is low, the block SHALL drive pc_write_o=0, if_id_write_o=0, if_id_flush_o=0, pipe_hold_o=0 and a bubbled ctrl_o.
REQ-023 Asserting reset SHALL asynchronously set state=RUN, the flush counter to 0, the saved state to RUN and both statistics counters to 0, including mid-FLUSH or mid-MEM_WAIT.
REQ-024 The first edge after reset release SHALL evaluate from RUN.

Structure
REQ-025 Package hazard_pkg SHALL hold the state enum and the default values of NCTRL, REG_AW and STAT_W.
REQ-026 The bubble gating SHALL be a sub-module ctrl_bubble_mux, parameterised by NCTRL and KEEP_MASK.
REQ-027 The FSM, the counters and the hazard comparator SHALL reside in hazard_control_unit.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Load x5 in EX with rs2=x5 used in ID -> one cycle with pc_write_o=0, bubble, stall_count_o=1; rd=x0 -> no stall.
- redirect_i for 1 cycle, FLUSH_CYCLES=3 -> if_id_flush_o high for exactly 3 cycles, flush_count_o=1.
- redirect_i again in the 2nd flush cycle -> flush extended to 2+3=5 total cycles, flush_count_o=2.
- mem_busy_i high 4 cycles in the 2nd flush cycle -> pipe_hold_o high for 4 cycles, then 2 remaining flush cycles.
- Load-use together with redirect_i -> flush wins, pc_write_o=1, no stall counted.
- STAT_W=2 with 5 stalls -> stall_count_o=3; clear_stats_i -> 0; reset low mid-MEM_WAIT -> RUN with counters 0.
